mul_operand_seq: RTL and testbench

//  Upstream feeder for the repeated-addition multiplier (datapath + controller).

---
 rtl/mul_operand_seq.sv | 201 ++++++++++++++++++++
 tb/tb_mul_operand_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_seq.sv
// Operand sequencer for the repeated-addition multiplier: FIFO of operand pairs, start/A/B bus
// sequencing, done wait with timeout, and a held result port. Optional: MUL_ZERO_BYPASS_EN.
module mul_operand_seq #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             mul_start_o,
  output logic             mul_rst_no,
  output logic [WIDTH-1:0] mul_data_o,
  input  logic             mul_done_i,
  input  logic [WIDTH-1:0] mul_prod_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic             res_err_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StOpA,
    StOpB,
    StWait,
    StRearm
  } state_e;

  state_e st_q, st_d;

  logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               op_ready_q, op_ready_d;
  logic               push, pop;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             mul_start_q, mul_start_d;
  logic             mul_rst_n_q, mul_rst_n_d;
  logic [WIDTH-1:0] mul_data_q, mul_data_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;

  // Ready comes from a registered full flag, so a pop never frees a slot in the same cycle.
  assign push = op_valid_i & op_ready_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= {op_a_i, op_b_i};
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    op_ready_d = (count_d != CntFull);
  end

  always_comb begin
    st_d        = st_q;
    pop         = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    tmo_d       = tmo_q;
    mul_start_d = 1'b0;
    mul_data_d  = mul_data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;

    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    case (st_q)
      StIdle: begin
        if ((count_q != '0) && !res_valid_q) begin
          pop        = 1'b1;
          {a_d, b_d} = mem_q[rptr_q];
`ifdef MUL_ZERO_BYPASS_EN
          if ((a_d == '0) || (b_d == '0)) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b0;
          end else begin
            st_d        = StStart;
            mul_start_d = 1'b1;
          end
`else
          st_d        = StStart;
          mul_start_d = 1'b1;
`endif
        end
      end
      StStart: begin
        st_d       = StOpA;
        mul_data_d = a_q;
      end
      StOpA: begin
        st_d       = StOpB;
        mul_data_d = b_q;
      end
      StOpB: begin
        st_d  = StWait;
        tmo_d = '0;
      end
      StWait: begin
        if (mul_done_i) begin
          res_data_d  = mul_prod_i;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          st_d        = StRearm;
        end else if (tmo_q == TmoLast) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          st_d        = StRearm;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRearm: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase

    // Controller re-arm is low only while the FSM sits in REARM.
    mul_rst_n_d = (st_d != StRearm);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q        <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      op_ready_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tmo_q       <= '0;
      mul_start_q <= 1'b0;
      mul_rst_n_q <= 1'b0;
      mul_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      op_ready_q  <= op_ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tmo_q       <= tmo_d;
      mul_start_q <= mul_start_d;
      mul_rst_n_q <= mul_rst_n_d;
      mul_data_q  <= mul_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign op_ready_o  = op_ready_q;
  assign mul_start_o = mul_start_q;
  assign mul_rst_no  = mul_rst_n_q;
  assign mul_data_o  = mul_data_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_mul_operand_seq.sv
// Bench for mul_operand_seq: behavioural repeated-addition multiplier plus a product reference
// model and result scoreboard.
module tb_mul_operand_seq;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid, op_ready;
  logic [W-1:0] op_a, op_b;
  logic         mul_start, mul_rst_n, mul_done;
  logic [W-1:0] mul_data, mul_prod;
  logic         res_valid, res_ready, res_err;
  logic [W-1:0] res_data;

  always #5 clk = ~clk;

  mul_operand_seq #(
    .WIDTH     (W),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .op_valid_i (op_valid),
    .op_ready_o (op_ready),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .mul_start_o(mul_start),
    .mul_rst_no (mul_rst_n),
    .mul_data_o (mul_data),
    .mul_done_i (mul_done),
    .mul_prod_i (mul_prod),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_data_o (res_data),
    .res_err_o  (res_err)
  );

  // Behavioural multiplier: start, load A, load B (clear P), add A per cycle, sticky done.
  int           m_ph;
  int           m_cnt;
  logic [W-1:0] m_a, m_p;
  logic         m_done;
  bit           kill_done = 1'b0;

  always @(posedge clk) begin
    if (!mul_rst_n) begin
      m_ph   <= 0;
      m_cnt  <= 0;
      m_p    <= '0;
      m_done <= 1'b0;
    end else begin
      case (m_ph)
        0: if (mul_start) m_ph <= 1;
        1: begin m_a <= mul_data; m_ph <= 2; end
        2: begin m_cnt <= int'(mul_data); m_p <= '0; m_ph <= 3; end
        3: begin
          m_p <= m_p + m_a;
          if (m_cnt <= 1) begin m_done <= 1'b1; m_ph <= 4; end
          else m_cnt <= m_cnt - 1;
        end
        default: ;
      endcase
    end
  end

  assign mul_done = m_done & ~kill_done;
  assign mul_prod = m_p;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_d[$];
  bit           exp_e[$];
  logic [W-1:0] got_d[$];
  bit           got_e[$];
  int           cyc = 0, acc_cyc = 0, rv_cyc = 0;
  int           n_start = 0, n_rearm = 0, ph = 0;
  logic [W-1:0] cap_a, cap_b;
  logic         prev_rv = 1'b0;

  function automatic logic [W-1:0] ref_prod(logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (Bypass && ((a == 0) || (b == 0))) return '0;
    if (b == 0) return a;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  // One clock: log handshakes due at the coming edge, then observe outputs at the next negedge.
  task automatic cycle();
    if (rst_n && op_valid && op_ready) begin
      exp_d.push_back(kill_done ? '0 : ref_prod(op_a, op_b));
      exp_e.push_back(kill_done);
      acc_cyc = cyc;
    end
    if (rst_n && res_valid && res_ready) begin
      got_d.push_back(res_data);
      got_e.push_back(res_err);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (!mul_rst_n) n_rearm++;
      if (ph == 1) begin cap_a = mul_data; ph = 2; end
      else if (ph == 2) begin cap_b = mul_data; ph = 0; end
      if (mul_start) begin n_start++; ph = 1; end
      if (res_valid && !prev_rv) rv_cyc = cyc;
    end
    prev_rv = res_valid;
  endtask

  task automatic clear_q();
    exp_d.delete(); exp_e.delete(); got_d.delete(); got_e.delete();
  endtask

  task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
    bit r;
    op_valid = 1'b1; op_a = a; op_b = b;
    for (int i = 0; i < 50; i++) begin
      r = op_ready;
      cycle();
      if (r) break;
    end
    op_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_d.size() >= n) break;
      cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    @(negedge clk);
    cycle(); cycle();
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready got=%b exp=0", op_ready); end
    checks++; if ({mul_start, mul_rst_n, res_valid, res_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {mul_start, mul_rst_n, res_valid, res_err});
    end
    checks++; if ({mul_data, res_data} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", mul_data, res_data);
    end
    rst_n = 1'b1;
    cycle();
    checks++; if ({op_ready, mul_rst_n, res_valid} !== 3'b110) begin
      errors++; $display("FAIL post_reset got=%b exp=110", {op_ready, mul_rst_n, res_valid});
    end
    clear_q();
  endtask

  task automatic test_single();
    int s0, r0;
    res_ready = 1'b1; clear_q(); s0 = n_start; r0 = n_rearm;
    push_one(16'd5, 16'd6);
    drain(1, 100);
    repeat (3) cycle();
    checks++; if (got_d.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got_d.size()); end
    else begin
      checks++; if (got_d[0] !== 16'd30) begin errors++; $display("FAIL single_data got=%0d exp=30", got_d[0]); end
      checks++; if (got_e[0] !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", got_e[0]); end
    end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL single_starts got=%0d exp=1", n_start - s0); end
    checks++; if ({cap_a, cap_b} !== {16'd5, 16'd6}) begin
      errors++; $display("FAIL single_bus got=%0d,%0d exp=5,6", cap_a, cap_b);
    end
    checks++; if (rv_cyc - acc_cyc != 12) begin errors++; $display("FAIL single_latency got=%0d exp=12", rv_cyc - acc_cyc); end
    checks++; if (n_rearm - r0 != 1) begin errors++; $display("FAIL single_rearm got=%0d exp=1", n_rearm - r0); end
  endtask

  task automatic test_back_to_back();
    bit r;
    res_ready = 1'b0; clear_q();
    op_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom_range(1, 12));
    for (int i = 0; i < 60; i++) begin
      r = op_ready;
      cycle();
      if (r) begin op_a = W'($urandom); op_b = W'($urandom_range(1, 12)); end
    end
    checks++; if (exp_d.size() != DEPTH + 1) begin
      errors++; $display("FAIL b2b_accepted got=%0d exp=%0d", exp_d.size(), DEPTH + 1);
    end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b exp=0", op_ready); end
    checks++; if (res_valid !== 1'b1 || exp_d.size() == 0 || res_data !== exp_d[0]) begin
      errors++; $display("FAIL b2b_hold got=%b/%h exp=1/%h", res_valid, res_data, exp_d.size() ? exp_d[0] : 16'h0);
    end
    op_valid = 1'b0; res_ready = 1'b1;
    drain(exp_d.size(), 400);
    checks++; if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++; if ({got_e[i], got_d[i]} !== {exp_e[i], exp_d[i]}) begin
        errors++; $display("FAIL b2b_result[%0d] got=%b/%h exp=%b/%h", i, got_e[i], got_d[i], exp_e[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_zero();
    int s0;
    res_ready = 1'b1; clear_q(); s0 = n_start;
    push_one(16'd3, 16'd0);
    drain(1, 60);
    repeat (3) cycle();
    checks++; if (got_d.size() != 1 || got_d[0] !== (Bypass ? 16'd0 : 16'd3) || got_e[0] !== 1'b0) begin
      errors++; $display("FAIL zero_b_result got=%0d/%h exp=1/%h", got_d.size(), got_d.size() ? got_d[0] : 16'h0,
                         Bypass ? 16'd0 : 16'd3);
    end
    checks++; if (n_start - s0 != (Bypass ? 0 : 1)) begin
      errors++; $display("FAIL zero_starts got=%0d exp=%0d", n_start - s0, Bypass ? 0 : 1);
    end
    checks++; if (rv_cyc - acc_cyc != (Bypass ? 2 : 7)) begin
      errors++; $display("FAIL zero_latency got=%0d exp=%0d", rv_cyc - acc_cyc, Bypass ? 2 : 7);
    end
    clear_q();
    push_one(16'd0, 16'd9);
    drain(1, 60);
    checks++; if (got_d.size() != 1 || got_d[0] !== 16'd0) begin
      errors++; $display("FAIL zero_a_result got=%0d/%h exp=1/0", got_d.size(), got_d.size() ? got_d[0] : 16'h0);
    end
  endtask

  task automatic test_timeout();
    int r0;
    res_ready = 1'b1; clear_q(); r0 = n_rearm; kill_done = 1'b1;
    push_one(16'd7, 16'd3);
    drain(1, 100);
    repeat (3) cycle();
    kill_done = 1'b0;
    checks++; if (got_d.size() != 1 || {got_e[0], got_d[0]} !== {1'b1, 16'd0}) begin
      errors++; $display("FAIL timeout_result got=%0d/%b/%h exp=1/1/0", got_d.size(),
                         got_e.size() ? got_e[0] : 1'b0, got_d.size() ? got_d[0] : 16'h0);
    end
    checks++; if (rv_cyc - acc_cyc != TMO + 5) begin
      errors++; $display("FAIL timeout_latency got=%0d exp=%0d", rv_cyc - acc_cyc, TMO + 5);
    end
    checks++; if (n_rearm - r0 != 1) begin errors++; $display("FAIL timeout_rearm got=%0d exp=1", n_rearm - r0); end
  endtask

  task automatic test_wrap();
    res_ready = 1'b1; clear_q();
    push_one(16'hFFFF, 16'd2);
    drain(1, 60);
    checks++; if (got_d.size() != 1 || {got_e[0], got_d[0]} !== {1'b0, 16'hFFFE}) begin
      errors++; $display("FAIL wrap_result got=%0d/%h exp=1/fffe", got_d.size(), got_d.size() ? got_d[0] : 16'h0);
    end
  endtask

  task automatic test_reset_wait();
    res_ready = 1'b1; clear_q();
    push_one(16'd9, 16'd12);
    repeat (6) cycle();
    rst_n = 1'b0;
    cycle();
    checks++; if ({op_ready, mul_start, mul_rst_n, res_valid, res_err} !== 5'b00000) begin
      errors++; $display("FAIL rstwait_ctrl got=%b exp=00000", {op_ready, mul_start, mul_rst_n, res_valid, res_err});
    end
    checks++; if ({mul_data, res_data} !== '0) begin
      errors++; $display("FAIL rstwait_data got=%h/%h exp=0/0", mul_data, res_data);
    end
    rst_n = 1'b1; clear_q();
    repeat (40) cycle();
    checks++; if (got_d.size() != 0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL rstwait_stale got=%0d/%b exp=0/1", got_d.size(), op_ready);
    end
    push_one(16'd2, 16'd3);
    drain(1, 60);
    checks++; if (got_d.size() != 1 || got_d[0] !== 16'd6) begin
      errors++; $display("FAIL rstwait_next got=%0d/%h exp=1/6", got_d.size(), got_d.size() ? got_d[0] : 16'h0);
    end
  endtask

  task automatic test_random();
    bit r;
    clear_q();
    op_valid = 1'b0;
    for (int i = 0; i < 3000 && exp_d.size() < 40; i++) begin
      if (!op_valid && ($urandom_range(0, 3) != 0)) begin
        op_valid = 1'b1;
        op_a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
        op_b = W'($urandom_range(0, 12));
      end
      res_ready = ($urandom_range(0, 2) != 0);
      r = op_valid && op_ready;
      cycle();
      if (r) op_valid = 1'b0;
    end
    op_valid = 1'b0; res_ready = 1'b1;
    drain(exp_d.size(), 600);
    checks++; if (exp_d.size() != 40 || got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++; if ({got_e[i], got_d[i]} !== {exp_e[i], exp_d[i]}) begin
        errors++; $display("FAIL rand_result[%0d] got=%b/%h exp=%b/%h", i, got_e[i], got_d[i], exp_e[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_timeout();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
